// File: rtl/button_event_pkg.sv
// Shared constants for the button event capture block: register map and
// readback field positions of the addr-3 event word.
package button_event_pkg;

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_EVENT = 2'd3;

    localparam int VALID_BIT = 31;
    localparam int OVF_BIT   = 30;
    localparam int TS_LSB    = 8;
    localparam int TS_WIDTH  = 16;

endpackage

// File: rtl/button_event_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO only lands when a
// pop happens in the same cycle, otherwise it is dropped.
module button_event_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/button_event_capture.sv
// Debounced button pulses -> sticky edge capture, masked irq and event FIFO
// behind an Avalon-MM slave. Define BUTTON_EVENT_TIMESTAMP_EN for timestamps.
module button_event_capture
    import button_event_pkg::*;
#(
    parameter int NUMBER_OF_INPUTS = 4,
    parameter int CODE_WIDTH       = 2,
    parameter int FIFO_DEPTH       = 8,
    parameter int FIFO_ADDR_WIDTH  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUMBER_OF_INPUTS-1:0] in_pulse,
    input  logic [1:0]                  address,
    input  logic                        chipselect,
    input  logic                        read,
    input  logic                        write,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic                        irq
);

    localparam int N = NUMBER_OF_INPUTS;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    localparam int EW = CODE_WIDTH + TS_WIDTH;
`else
    localparam int EW = CODE_WIDTH;
`endif

    logic [N-1:0]          in_pulse_d;
    logic [N-1:0]          rise;
    logic [N-1:0]          edge_capture;
    logic [N-1:0]          irq_mask;
    logic [N-1:0]          pending;
    logic [N-1:0]          pend_clr;
    logic [CODE_WIDTH-1:0] code;
    logic                  found;
    logic                  overflow;
    logic                  rd_en;
    logic                  wr_en;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic [EW-1:0]         din;
    logic [EW-1:0]         head;
    logic [31:0]           event_word;
    logic [31:0]           rd_mux;
    logic                  unused_wdata;

    assign unused_wdata = ^writedata[31:N];
    assign rise  = in_pulse & ~in_pulse_d;
    assign rd_en = chipselect & read;
    assign wr_en = chipselect & write;
    assign pop   = rd_en & (address == ADDR_EVENT) & ~empty;

    // Lowest-index pending button wins the single push slot this cycle.
    always_comb begin
        code     = '0;
        found    = 1'b0;
        pend_clr = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i] && !found) begin
                code        = CODE_WIDTH'(i);
                found       = 1'b1;
                pend_clr[i] = 1'b1;
            end
        end
    end

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk) begin
        if (reset) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    assign din = {ts, code};
`else
    assign din = code;
`endif

    button_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (found),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        event_word            = '0;
        event_word[VALID_BIT] = ~empty;
        event_word[OVF_BIT]   = overflow;
        if (!empty) begin
            event_word[CODE_WIDTH-1:0] = head[CODE_WIDTH-1:0];
`ifdef BUTTON_EVENT_TIMESTAMP_EN
            event_word[TS_LSB +: TS_WIDTH] = head[CODE_WIDTH +: TS_WIDTH];
`endif
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_LEVEL: rd_mux = 32'(in_pulse);
            ADDR_MASK:  rd_mux = 32'(irq_mask);
            ADDR_EDGE:  rd_mux = 32'(edge_capture);
            default:    rd_mux = event_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_pulse_d   <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            pending      <= '0;
            overflow     <= 1'b0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            in_pulse_d <= in_pulse;
            pending    <= (pending & ~pend_clr) | rise;
            irq        <= |(edge_capture & irq_mask);
            readdata   <= rd_en ? rd_mux : '0;
            if (wr_en && address == ADDR_EDGE)
                edge_capture <= (edge_capture & ~writedata[N-1:0]) | rise;
            else
                edge_capture <= edge_capture | rise;
            if (wr_en && address == ADDR_MASK)
                irq_mask <= writedata[N-1:0];
            // A dropped push keeps the flag set even if cleared this cycle.
            if (found && full && !pop)
                overflow <= 1'b1;
            else if (wr_en && address == ADDR_EVENT)
                overflow <= 1'b0;
        end
    end

endmodule
